// File: rtl/lsu_ctrl.sv
// Load/store requester for the stage-M data memory: range/size-checks one request
// at a time, issues the access and returns one response per request.
module lsu_ctrl #(
    parameter int unsigned SIZE_LOG2 = 13,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic                 mem_signed,
    output logic [SIZE_LOG2-1:0] mem_a,
    output logic [31:0]          mem_wd,
    input  logic [31:0]          mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t               state;
    logic                 signedQ;
    logic [1:0]           sizeQ;
    logic [SIZE_LOG2-1:0] addrQ;
    logic [31:0]          rspDataQ;
    logic [TAG_W-1:0]     rspTagQ;
    logic                 rspErrQ;

    logic                 sizeBad;
    logic                 highBad;
    logic                 wrapBad;
    logic                 err;
    logic                 accept;
    logic [1:0]           lastOff;
    logic [SIZE_LOG2:0]   endAddr;

    // Offset of the last byte touched; the carry out of endAddr flags an access
    // that would run past the top of memory and wrap to address 0.
    always_comb begin
        lastOff = 2'd0;
        case (req_size)
            2'b01:   lastOff = 2'd1;
            2'b10:   lastOff = 2'd3;
            default: lastOff = 2'd0;
        endcase
    end

    assign endAddr = {1'b0, req_addr[SIZE_LOG2-1:0]} + {{(SIZE_LOG2-1){1'b0}}, lastOff};
    assign sizeBad = (req_size == 2'b11);
    assign highBad = |req_addr[31:SIZE_LOG2];
    assign wrapBad = endAddr[SIZE_LOG2];
    assign err     = sizeBad | highBad | wrapBad;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == RSP);
    assign rsp_data  = rspDataQ;
    assign rsp_tag   = rspTagQ;
    assign rsp_err   = rspErrQ;

    assign mem_we = accept & req_we & ~err;
    assign mem_wd = req_wdata;

    // Outside IDLE the memory sees the held load parameters, since it applies
    // sign extension combinationally in the data cycle.
    always_comb begin
        mem_a      = addrQ;
        mem_size   = sizeQ;
        mem_signed = signedQ;
        if (state == IDLE) begin
            mem_a      = req_addr[SIZE_LOG2-1:0];
            mem_size   = req_size;
            mem_signed = req_signed;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            signedQ  <= 1'b0;
            sizeQ    <= '0;
            addrQ    <= '0;
            rspDataQ <= '0;
            rspTagQ  <= '0;
            rspErrQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rspTagQ <= req_tag;
                        if (err) begin
                            rspErrQ  <= 1'b1;
                            rspDataQ <= '0;
                            state    <= RSP;
                        end else if (req_we) begin
                            rspErrQ  <= 1'b0;
                            rspDataQ <= '0;
                            state    <= RSP;
                        end else begin
                            rspErrQ <= 1'b0;
                            signedQ <= req_signed;
                            sizeQ   <= req_size;
                            addrQ   <= req_addr[SIZE_LOG2-1:0];
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    rspDataQ <= mem_rd;
                    state    <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressable little-endian memory model
// (registered read address, combinational alignment and sign extension).
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_err;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [12:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int tests = 0;
    int fails = 0;
    logic weSeen = 1'b0;

    always #5 clk = ~clk;

    lsu_ctrl #(.SIZE_LOG2(13), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    logic [7:0]  mem [0:8191];
    logic [12:0] rdA = '0;
    logic [1:0]  rdS = '0;

    always @(posedge clk) begin
        rdA <= mem_a;
        rdS <= mem_size;
        if (mem_we === 1'b1) begin
            weSeen = 1'b1;
            mem[mem_a] <= mem_wd[7:0];
            if (mem_size != 2'b00) mem[mem_a + 13'd1] <= mem_wd[15:8];
            if (mem_size == 2'b10) begin
                mem[mem_a + 13'd2] <= mem_wd[23:16];
                mem[mem_a + 13'd3] <= mem_wd[31:24];
            end
        end
    end

    always @* begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[rdA];
        b1 = mem[rdA + 13'd1];
        b2 = mem[rdA + 13'd2];
        b3 = mem[rdA + 13'd3];
        case (rdS)
            2'b00:   mem_rd = {{24{mem_signed & b0[7]}}, b0};
            2'b01:   mem_rd = {{16{mem_signed & b1[7]}}, b1, b0};
            default: mem_rd = {b3, b2, b1, b0};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response with rsp_ready high; checks latency and payload.
    task automatic transact(input string nm, input logic we, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] tag, input logic expErr, input logic [31:0] expData);
        weSeen     = 1'b0;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_tag    = tag;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".memWe"}, 32'(mem_we), 32'(we & ~expErr));
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!we && !expErr) begin
            chk({nm, ".latency"}, 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk({nm, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, ".data"}, rsp_data, expData);
        chk({nm, ".tag"}, 32'(rsp_tag), 32'(tag));
        chk({nm, ".err"}, 32'(rsp_err), 32'(expErr));
        @(posedge clk); #1;
        chk({nm, ".done"}, 32'(rsp_valid), 32'd0);
        if (expErr) chk({nm, ".noWrite"}, 32'(weSeen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_tag = '0; rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.data", rsp_data, 32'd0);
        chk("rst.tag", 32'(rsp_tag), 32'd0);
        chk("rst.memWe", 32'(mem_we), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        transact("stW100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 1'b0, 32'h0);
        transact("ldW100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 1'b0, 32'hDEADBEEF);
        transact("ldBs103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd1, 1'b0, 32'hFFFFFFDE);
        transact("ldBu103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd2, 1'b0, 32'h000000DE);
        transact("ldHs102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd4, 1'b0, 32'hFFFFDEAD);
        transact("stH1FF", 1'b1, 2'b01, 1'b0, 32'h1FF, 32'h0000A55A, 5'd5, 1'b0, 32'h0);
        transact("ldHu1FF", 1'b0, 2'b01, 1'b0, 32'h1FF, 32'h0, 5'd6, 1'b0, 32'h0000A55A);
        transact("stWtop", 1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h11223344, 5'd8, 1'b0, 32'h0);
        transact("ldHtop", 1'b0, 2'b01, 1'b1, 32'h1FFE, 32'h0, 5'd9, 1'b0, 32'h00001122);
        transact("ldBlast", 1'b0, 2'b00, 1'b1, 32'h1FFF, 32'h0, 5'd10, 1'b0, 32'h00000011);

        transact("errLd2000", 1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 5'd11, 1'b1, 32'h0);
        transact("errStW1FFE", 1'b1, 2'b10, 1'b0, 32'h1FFE, 32'hCAFEF00D, 5'd12, 1'b1, 32'h0);
        transact("errSize11", 1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678, 5'd13, 1'b1, 32'h0);
        transact("errLdH1FFF", 1'b0, 2'b01, 1'b0, 32'h1FFF, 32'h0, 5'd14, 1'b1, 32'h0);
        transact("chkNoClobber", 1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 5'd15, 1'b0, 32'h11223344);

        // Backpressure: response held for 3 cycles while a store waits at the input.
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100;
        req_tag = 5'd12; rsp_ready = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h00000077; req_tag = 5'd4;
        chk("bp.loadLat", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp.valid", 32'(rsp_valid), 32'd1);
        chk("bp.data", rsp_data, 32'hDEADBEEF);
        chk("bp.tag", 32'(rsp_tag), 32'd12);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.holdValid", 32'(rsp_valid), 32'd1);
            chk("bp.holdData", rsp_data, 32'hDEADBEEF);
            chk("bp.holdTag", 32'(rsp_tag), 32'd12);
            chk("bp.holdReady", 32'(req_ready), 32'd0);
            chk("bp.holdMemWe", 32'(mem_we), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.hsReady", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp.afterHsValid", 32'(rsp_valid), 32'd0);
        chk("bp.afterHsReady", 32'(req_ready), 32'd1);
        chk("bp.afterHsMemWe", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp.nextValid", 32'(rsp_valid), 32'd1);
        chk("bp.nextTag", 32'(rsp_tag), 32'd4);
        @(posedge clk); #1;
        transact("bp.ldB10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 5'd16, 1'b0, 32'h00000077);

        // Reset while in LOAD: the load is abandoned without a response.
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100;
        req_tag = 5'd9; rsp_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstLd.inLoad", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstLd.valid", 32'(rsp_valid), 32'd0);
        chk("rstLd.idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstLd.noRsp", 32'(rsp_valid), 32'd0);
        transact("rstLd.reload", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd17, 1'b0, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
